sse_out_packer: RTL and testbench

- Sits between the ScaleSpaceExtrema image output port (24-bit pixel stream, ready/valid) and the 32-bit image output FIFO write side.
- Packs 24-bit pixels densely into 32-bit words: 4 pixels become 3 words, little-endian byte order.
- Flushes a zero-padded residual word at every frame boundary, so host-side reads are never lost mid-frame.
- Provides frame/word status counters for the mem_8 register readback path.

---
 rtl/sse_out_packer_if.sv | 22 ++
 rtl/sse_out_packer.sv | 139 +++++++++++++
 tb/tb_sse_out_packer.sv | 332 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sse_out_packer_if.sv
// Stream bundle between the ScaleSpaceExtrema pixel output and the 32-bit
// image output FIFO write side: a 24-bit pixel stream in, a 32-bit word out.
interface sse_out_packer_if;
  logic        in_valid;
  logic        in_ready;
  logic [23:0] in_bits;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_bits;

  // Environment side: supplies pixels and the FIFO-not-full back-pressure.
  modport master (
    output in_valid, in_bits, out_ready,
    input  in_ready, out_valid, out_bits
  );

  // Packer side: consumes pixels and presents packed words.
  modport slave (
    input  in_valid, in_bits, out_ready,
    output in_ready, out_valid, out_bits
  );
endinterface

// File: rtl/sse_out_packer.sv
// Packs 24-bit pixels densely into 32-bit little-endian words (4 pixels ->
// 3 words), flushing a zero-padded residual word at each frame boundary so a
// frame never leaves bytes stranded inside the packer. Also keeps frame and
// word status counters for register readback.
module sse_out_packer #(
  parameter int unsigned FRAME_PIXELS = 307200,
  parameter int unsigned PIX_CNT_W    = 20
) (
  input  logic            bus_clk,
  input  logic            reset_n,
  sse_out_packer_if.slave pk,
  output logic            frame_done,
  output logic [7:0]      frame_count,
  output logic [15:0]     word_count
);

  typedef enum logic [1:0] {PH0, PH1, PH2, PH3} phase_t;

  localparam logic [PIX_CNT_W-1:0] LAST_PIX = PIX_CNT_W'(FRAME_PIXELS - 1);

  phase_t                 phase_q, phase_d;
  logic [PIX_CNT_W-1:0]   pixCnt_q, pixCnt_d;
  logic [23:0]            resid_q, resid_d;
  logic                   flushPending_q, flushPending_d;
  logic                   outValid_q, outValid_d;
  logic [31:0]            outBits_q, outBits_d;
  logic                   outLast_q, outLast_d;
  logic                   frameDone_q, frameDone_d;
  logic [7:0]             frameCount_q, frameCount_d;
  logic [15:0]            wordCount_q, wordCount_d;

  logic canLoad;
  logic accept;
  logic lastPix;
  logic drain;

  // The output register may be (re)loaded when it is empty or draining this cycle.
  assign canLoad     = !outValid_q || pk.out_ready;
  assign pk.in_ready = !flushPending_q && canLoad;
  assign accept      = pk.in_valid && pk.in_ready;
  assign lastPix     = (pixCnt_q == LAST_PIX);
  assign drain       = outValid_q && pk.out_ready;

  assign pk.out_valid = outValid_q;
  assign pk.out_bits  = outBits_q;
  assign frame_done   = frameDone_q;
  assign frame_count  = frameCount_q;
  assign word_count   = wordCount_q;

  // Next-state: pack by phase, handle end-of-frame, flush and the status counters.
  always_comb begin
    phase_d        = phase_q;
    pixCnt_d       = pixCnt_q;
    resid_d        = resid_q;
    flushPending_d = flushPending_q;
    outValid_d     = outValid_q && !pk.out_ready;
    outBits_d      = outBits_q;
    outLast_d      = outLast_q;
    frameDone_d    = drain && outLast_q;
    frameCount_d   = frameCount_q + 8'(frameDone_d);
    wordCount_d    = wordCount_q + 16'(drain);

    if (flushPending_q) begin
      if (canLoad) begin
        outValid_d     = 1'b1;
        outBits_d      = {8'h00, resid_q};
        outLast_d      = 1'b1;
        flushPending_d = 1'b0;
        resid_d        = '0;
      end
    end else if (accept) begin
      pixCnt_d = lastPix ? '0 : pixCnt_q + PIX_CNT_W'(1);
      unique case (phase_q)
        PH0: begin
          if (lastPix) begin
            outValid_d = 1'b1;
            outBits_d  = {8'h00, pk.in_bits};
            outLast_d  = 1'b1;
            phase_d    = PH0;
          end else begin
            resid_d = pk.in_bits;
            phase_d = PH1;
          end
        end
        PH1: begin
          outValid_d     = 1'b1;
          outBits_d      = {pk.in_bits[7:0], resid_q};
          outLast_d      = 1'b0;
          resid_d        = {8'h00, pk.in_bits[23:8]};
          flushPending_d = lastPix;
          phase_d        = lastPix ? PH0 : PH2;
        end
        PH2: begin
          outValid_d     = 1'b1;
          outBits_d      = {pk.in_bits[15:0], resid_q[15:0]};
          outLast_d      = 1'b0;
          resid_d        = {16'h0000, pk.in_bits[23:16]};
          flushPending_d = lastPix;
          phase_d        = lastPix ? PH0 : PH3;
        end
        PH3: begin
          outValid_d = 1'b1;
          outBits_d  = {pk.in_bits, resid_q[7:0]};
          outLast_d  = lastPix;
          resid_d    = '0;
          phase_d    = PH0;
        end
      endcase
    end
  end

  // State register with synchronous active-low reset; reset drops any held word.
  always_ff @(posedge bus_clk) begin
    if (!reset_n) begin
      phase_q        <= PH0;
      pixCnt_q       <= '0;
      resid_q        <= '0;
      flushPending_q <= 1'b0;
      outValid_q     <= 1'b0;
      outBits_q      <= '0;
      outLast_q      <= 1'b0;
      frameDone_q    <= 1'b0;
      frameCount_q   <= '0;
      wordCount_q    <= '0;
    end else begin
      phase_q        <= phase_d;
      pixCnt_q       <= pixCnt_d;
      resid_q        <= resid_d;
      flushPending_q <= flushPending_d;
      outValid_q     <= outValid_d;
      outBits_q      <= outBits_d;
      outLast_q      <= outLast_d;
      frameDone_q    <= frameDone_d;
      frameCount_q   <= frameCount_d;
      wordCount_q    <= wordCount_d;
    end
  end

endmodule

// File: tb/tb_sse_out_packer.sv
// Scoreboard bench for sse_out_packer. Three packers with different frame
// sizes share one clock/reset; expected words are queued per packer before
// the stimulus and a negedge monitor pops and compares accepted words and
// the frame_done pulse that follows a frame's final word.
module tb_sse_out_packer;

  typedef struct packed {
    logic [31:0] w;
    logic        last;
  } exp_t;

  logic clk;
  logic reset_n;

  sse_out_packer_if ifA ();
  sse_out_packer_if ifB ();
  sse_out_packer_if ifC ();

  logic        doneA, doneB, doneC;
  logic [7:0]  fcA, fcB, fcC;
  logic [15:0] wcA, wcB, wcC;

  exp_t qA[$];
  exp_t qB[$];
  exp_t qC[$];

  logic expDone[3];
  int   doneCnt[3];
  int   testsRun;
  int   failCount;
  int   stallCycles;

  sse_out_packer #(.FRAME_PIXELS(4), .PIX_CNT_W(20)) dutA (
    .bus_clk(clk), .reset_n(reset_n), .pk(ifA),
    .frame_done(doneA), .frame_count(fcA), .word_count(wcA)
  );

  sse_out_packer #(.FRAME_PIXELS(5), .PIX_CNT_W(20)) dutB (
    .bus_clk(clk), .reset_n(reset_n), .pk(ifB),
    .frame_done(doneB), .frame_count(fcB), .word_count(wcB)
  );

  sse_out_packer #(.FRAME_PIXELS(6), .PIX_CNT_W(20)) dutC (
    .bus_clk(clk), .reset_n(reset_n), .pk(ifC),
    .frame_done(doneC), .frame_count(fcC), .word_count(wcC)
  );

  // Free-running clock, 10 time units per cycle.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case the run wedges somewhere unbounded.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
    testsRun++;
    if (got !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic pushExp(input int d, input logic [31:0] w, input logic last);
    exp_t item;
    item.w    = w;
    item.last = last;
    case (d)
      0:       qA.push_back(item);
      1:       qB.push_back(item);
      default: qC.push_back(item);
    endcase
  endtask

  task automatic popExp(input int d, output exp_t item, output logic ok);
    ok   = 1'b0;
    item = '0;
    case (d)
      0:       if (qA.size() > 0) begin item = qA.pop_front(); ok = 1'b1; end
      1:       if (qB.size() > 0) begin item = qB.pop_front(); ok = 1'b1; end
      default: if (qC.size() > 0) begin item = qC.pop_front(); ok = 1'b1; end
    endcase
  endtask

  task automatic setIn(input int d, input logic v, input logic [23:0] pix);
    case (d)
      0:       begin ifA.in_valid = v; ifA.in_bits = pix; end
      1:       begin ifB.in_valid = v; ifB.in_bits = pix; end
      default: begin ifC.in_valid = v; ifC.in_bits = pix; end
    endcase
  endtask

  function automatic logic getReady(input int d);
    case (d)
      0:       return ifA.in_ready;
      1:       return ifB.in_ready;
      default: return ifC.in_ready;
    endcase
  endfunction

  // Offer one pixel and hold it until accepted (bounded wait).
  task automatic applyStimulus(input int d, input logic [23:0] pix);
    int waitCyc;
    waitCyc = 0;
    setIn(d, 1'b1, pix);
    @(negedge clk);
    while (!getReady(d) && waitCyc < 40) begin
      @(negedge clk);
      waitCyc++;
    end
    stallCycles += waitCyc;
    if (!getReady(d)) begin
      testsRun++;
      failCount++;
      $display("[TB] FAIL in_ready timeout dut%0d: got 0 expected 1", d);
    end
    @(posedge clk);
    #1;
    setIn(d, 1'b0, 24'h0);
  endtask

  task automatic monitorDut(input int d, input logic v, input logic r,
                            input logic [31:0] bits, input logic done);
    exp_t item;
    logic ok;
    if (done === 1'b1) doneCnt[d]++;
    if (done === 1'b1 || expDone[d])
      checkOutput($sformatf("frame_done dut%0d", d), 32'(done), 32'(expDone[d]));
    expDone[d] = 1'b0;
    if (v === 1'b1 && r === 1'b1) begin
      popExp(d, item, ok);
      if (!ok) begin
        testsRun++;
        failCount++;
        $display("[TB] FAIL unexpected word dut%0d: got 0x%0h expected none", d, bits);
      end else begin
        checkOutput($sformatf("word dut%0d", d), bits, item.w);
        expDone[d] = item.last;
      end
    end
  endtask

  // Scoreboard monitor: compare every accepted output word and frame_done pulse.
  always @(negedge clk) begin
    monitorDut(0, ifA.out_valid, ifA.out_ready, ifA.out_bits, doneA);
    monitorDut(1, ifB.out_valid, ifB.out_ready, ifB.out_bits, doneB);
    monitorDut(2, ifC.out_valid, ifC.out_ready, ifC.out_bits, doneC);
  end

  function automatic logic [23:0] seqPix(input int n);
    return {8'(n + 2), 8'(n + 1), 8'(n)};
  endfunction

  function automatic logic [31:0] seqWord(input int n);
    return {8'(n + 3), 8'(n + 2), 8'(n + 1), 8'(n)};
  endfunction

  task automatic resetAll();
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    testsRun    = 0;
    failCount   = 0;
    stallCycles = 0;
    for (int i = 0; i < 3; i++) begin
      expDone[i] = 1'b0;
      doneCnt[i] = 0;
    end
    reset_n = 1'b0;
    ifA.in_valid = 1'b0; ifA.in_bits = '0; ifA.out_ready = 1'b1;
    ifB.in_valid = 1'b0; ifB.in_bits = '0; ifB.out_ready = 1'b1;
    ifC.in_valid = 1'b0; ifC.in_bits = '0; ifC.out_ready = 1'b1;

    // Reset values.
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset out_valid A", 32'(ifA.out_valid), 32'd0);
    checkOutput("reset out_bits A", ifA.out_bits, 32'd0);
    checkOutput("reset frame_done A", 32'(doneA), 32'd0);
    checkOutput("reset frame_count A", 32'(fcA), 32'd0);
    checkOutput("reset word_count A", 32'(wcA), 32'd0);
    checkOutput("reset out_valid B", 32'(ifB.out_valid), 32'd0);
    checkOutput("reset word_count C", 32'(wcC), 32'd0);
    reset_n = 1'b1;
    idle(2);

    // Continuous stream, one frame of 4 pixels on A.
    pushExp(0, 32'h04030201, 1'b0);
    pushExp(0, 32'h08070605, 1'b0);
    pushExp(0, 32'h0C0B0A09, 1'b1);
    stallCycles = 0;
    applyStimulus(0, 24'h030201);
    applyStimulus(0, 24'h060504);
    applyStimulus(0, 24'h090807);
    applyStimulus(0, 24'h0C0B0A);
    checkOutput("stream stalls A", 32'(stallCycles), 32'd0);
    idle(4);
    checkOutput("frame_count after stream A", 32'(fcA), 32'd1);
    checkOutput("word_count after stream A", 32'(wcA), 32'd3);

    // Back-pressure: out_ready low for 10 cycles with a word held.
    pushExp(0, 32'h04030201, 1'b0);
    pushExp(0, 32'h08070605, 1'b0);
    pushExp(0, 32'h0C0B0A09, 1'b1);
    pushExp(0, 32'h100F0E0D, 1'b0);
    pushExp(0, 32'h14131211, 1'b0);
    pushExp(0, 32'h18171615, 1'b1);
    fork
      begin
        applyStimulus(0, 24'h030201);
        applyStimulus(0, 24'h060504);
        applyStimulus(0, 24'h090807);
        applyStimulus(0, 24'h0C0B0A);
        applyStimulus(0, 24'h0F0E0D);
        applyStimulus(0, 24'h121110);
        applyStimulus(0, 24'h151413);
        applyStimulus(0, 24'h181716);
      end
      begin
        repeat (2) @(posedge clk);
        #2;
        ifA.out_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
          @(negedge clk);
          checkOutput("backpressure in_ready A", 32'(ifA.in_ready), 32'd0);
          checkOutput("backpressure out_valid A", 32'(ifA.out_valid), 32'd1);
          checkOutput("backpressure out_bits A", ifA.out_bits, 32'h04030201);
        end
        @(posedge clk);
        #2;
        ifA.out_ready = 1'b1;
      end
    join
    idle(4);
    checkOutput("word_count after backpressure A", 32'(wcA), 32'd9);
    checkOutput("frame_count after backpressure A", 32'(fcA), 32'd3);

    // Frame of 5 on B: last pixel lands in phase 0.
    pushExp(1, 32'h22111111, 1'b0);
    pushExp(1, 32'h33332222, 1'b0);
    pushExp(1, 32'h44444433, 1'b0);
    pushExp(1, 32'h00555555, 1'b1);
    applyStimulus(1, 24'h111111);
    applyStimulus(1, 24'h222222);
    applyStimulus(1, 24'h333333);
    applyStimulus(1, 24'h444444);
    applyStimulus(1, 24'h555555);
    idle(4);
    checkOutput("frame_count B", 32'(fcB), 32'd1);
    checkOutput("word_count B", 32'(wcB), 32'd4);
    checkOutput("frame_done pulses B", 32'(doneCnt[1]), 32'd1);

    // Frame of 6 on C: last pixel in phase 1 forces a flush word.
    pushExp(2, 32'h22111111, 1'b0);
    pushExp(2, 32'h33332222, 1'b0);
    pushExp(2, 32'h44444433, 1'b0);
    pushExp(2, 32'h44555555, 1'b0);
    pushExp(2, 32'h00006655, 1'b1);
    applyStimulus(2, 24'h111111);
    applyStimulus(2, 24'h222222);
    applyStimulus(2, 24'h333333);
    applyStimulus(2, 24'h444444);
    applyStimulus(2, 24'h555555);
    applyStimulus(2, 24'h665544);
    @(negedge clk);
    checkOutput("flush in_ready low C", 32'(ifC.in_ready), 32'd0);
    @(negedge clk);
    checkOutput("flush in_ready back C", 32'(ifC.in_ready), 32'd1);
    idle(4);
    checkOutput("frame_count C", 32'(fcC), 32'd1);
    checkOutput("word_count C", 32'(wcC), 32'd5);

    // Reset mid-frame (phase 2, word held) then a clean frame from phase 0.
    ifA.out_ready = 1'b0;
    applyStimulus(0, 24'hDEAD01);
    applyStimulus(0, 24'hBEEF02);
    resetAll();
    checkOutput("midreset out_valid A", 32'(ifA.out_valid), 32'd0);
    checkOutput("midreset out_bits A", ifA.out_bits, 32'd0);
    checkOutput("midreset frame_count A", 32'(fcA), 32'd0);
    checkOutput("midreset word_count A", 32'(wcA), 32'd0);
    ifA.out_ready = 1'b1;
    pushExp(0, 32'h44332211, 1'b0);
    pushExp(0, 32'h88776655, 1'b0);
    pushExp(0, 32'hCCBBAA99, 1'b1);
    applyStimulus(0, 24'h332211);
    applyStimulus(0, 24'h665544);
    applyStimulus(0, 24'h998877);
    applyStimulus(0, 24'hCCBBAA);
    idle(4);
    checkOutput("after reset word_count A", 32'(wcA), 32'd3);

    // 256 frames of 4 pixels: frame_count wraps, word_count counts all.
    resetAll();
    doneCnt[0] = 0;
    for (int f = 0; f < 256; f++) begin
      for (int k = 0; k < 3; k++) pushExp(0, seqWord(12 * f + 4 * k), (k == 2));
      for (int j = 0; j < 4; j++) applyStimulus(0, seqPix(12 * f + 3 * j));
      if (f == 254) begin
        idle(4);
        checkOutput("frame_count at 255 A", 32'(fcA), 32'd255);
      end
    end
    idle(4);
    checkOutput("frame_count wrap A", 32'(fcA), 32'd0);
    checkOutput("word_count 768 A", 32'(wcA), 32'd768);
    checkOutput("frame_done pulses A", 32'(doneCnt[0]), 32'd256);

    idle(4);
    checkOutput("queue A drained", 32'(qA.size()), 32'd0);
    checkOutput("queue B drained", 32'(qB.size()), 32'd0);
    checkOutput("queue C drained", 32'(qC.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
